// File: rtl/complete_bus_arbiter.sv
// Round-robin arbiter that grants up to NUM_BUS writeback requesters per cycle onto registered complete buses.
// Optional tag checker (duplicate / zero tags among grants) enabled by COMPLETE_BUS_ARB_CHECK_EN.
module complete_bus_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_BUS = 3,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_BUS-1:0]        bus_valid,
  output logic [NUM_BUS*TAG_W-1:0]  bus_tag,
  output logic [NUM_BUS*DATA_W-1:0] bus_data,
  output logic [NUM_BUS*SRC_W-1:0]  bus_src,
  output logic                      DUT_error
);

  localparam int unsigned CNT_W = $clog2(NUM_BUS + 1);
  localparam int unsigned IDX_W = SRC_W + 1;

  logic [SRC_W-1:0]          rr_ptr;
  logic [SRC_W-1:0]          rr_ptr_nxt;
  logic [IDX_W-1:0]          idx_sum;
  logic [SRC_W-1:0]          idx;
  logic [CNT_W-1:0]          cnt;
  logic [NUM_BUS-1:0]        nxt_valid;
  logic [NUM_BUS*TAG_W-1:0]  nxt_tag;
  logic [NUM_BUS*DATA_W-1:0] nxt_data;
  logic [NUM_BUS*SRC_W-1:0]  nxt_src;

  // Scan from rr_ptr; the j-th valid requester found lands on bus j.
  always_comb begin
    req_ready  = '0;
    nxt_valid  = '0;
    nxt_tag    = '0;
    nxt_data   = '0;
    nxt_src    = '0;
    rr_ptr_nxt = rr_ptr;
    cnt        = '0;
    idx_sum    = '0;
    idx        = '0;
    for (int unsigned o = 0; o < NUM_REQ; o++) begin
      idx_sum = IDX_W'(rr_ptr) + IDX_W'(o);
      if (idx_sum >= IDX_W'(NUM_REQ)) begin
        idx_sum = idx_sum - IDX_W'(NUM_REQ);
      end
      idx = idx_sum[SRC_W-1:0];
      if (req_valid[idx] && (cnt < CNT_W'(NUM_BUS))) begin
        req_ready[idx]                  = 1'b1;
        nxt_valid[cnt]                  = 1'b1;
        nxt_tag[cnt*TAG_W +: TAG_W]     = req_tag[idx*TAG_W +: TAG_W];
        nxt_data[cnt*DATA_W +: DATA_W]  = req_data[idx*DATA_W +: DATA_W];
        nxt_src[cnt*SRC_W +: SRC_W]     = idx;
        rr_ptr_nxt = (idx == SRC_W'(NUM_REQ - 1)) ? '0 : idx + SRC_W'(1);
        cnt        = cnt + CNT_W'(1);
      end
    end
  end

  // Every bus is rewritten each cycle so idle buses fall back to zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr    <= '0;
      bus_valid <= '0;
      bus_tag   <= '0;
      bus_data  <= '0;
      bus_src   <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      bus_valid <= nxt_valid;
      bus_tag   <= nxt_tag;
      bus_data  <= nxt_data;
      bus_src   <= nxt_src;
    end
  end

`ifdef COMPLETE_BUS_ARB_CHECK_EN
  logic err_c;

  // Flag a zero tag or a tag shared by two grants in the same cycle.
  always_comb begin
    err_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && (req_tag[i*TAG_W +: TAG_W] == '0)) begin
        err_c = 1'b1;
      end
      for (int unsigned j = i + 1; j < NUM_REQ; j++) begin
        if (req_ready[i] && req_ready[j] &&
            (req_tag[i*TAG_W +: TAG_W] == req_tag[j*TAG_W +: TAG_W])) begin
          err_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      DUT_error <= 1'b0;
    end else if (err_c) begin
      DUT_error <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (nRST && err_c) begin
      $display("[complete_bus_arbiter] tag error t=%0t granted_src=%b tags=%h",
               $realtime, req_ready, req_tag);
    end
  end
`endif
`else
  assign DUT_error = 1'b0;
`endif

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// Directed bench for complete_bus_arbiter: stimulus pushes expected bus state, a monitor pops and compares.
module tb_complete_bus_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned NUM_BUS = 3;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SRC_W   = 2;
`ifdef COMPLETE_BUS_ARB_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [NUM_BUS-1:0]        v;
    logic [NUM_BUS*TAG_W-1:0]  tag;
    logic [NUM_BUS*DATA_W-1:0] data;
    logic [NUM_BUS*SRC_W-1:0]  src;
    logic                      err;
  } exp_t;

  logic                      CLK;
  logic                      nRST;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_BUS-1:0]        bus_valid;
  logic [NUM_BUS*TAG_W-1:0]  bus_tag;
  logic [NUM_BUS*DATA_W-1:0] bus_data;
  logic [NUM_BUS*SRC_W-1:0]  bus_src;
  logic                      DUT_error;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   err_model = 1'b0;

  complete_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_BUS(NUM_BUS), .TAG_W(TAG_W), .DATA_W(DATA_W), .SRC_W(SRC_W)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_data(req_data),
    .bus_valid(bus_valid), .bus_tag(bus_tag), .bus_data(bus_data), .bus_src(bus_src),
    .DUT_error(DUT_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] tg(input int t3, input int t2, input int t1, input int t0);
    return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
  endfunction

  function automatic logic [31:0] mkdata(input int i, input logic [5:0] t);
    return 32'hDA7A_0000 | (32'(i) << 8) | 32'(t);
  endfunction

  // Drive one cycle of requests, check comb grants, queue the bus state due next cycle.
  task automatic step(input logic [3:0] v, input logic [23:0] tags, input logic [3:0] exp_rdy,
                      input logic [2:0] exp_bv, input logic [5:0] exp_src, input bit err_evt);
    exp_t e;
    int   s;
    logic [5:0] t;
    req_valid = v;
    req_tag   = tags;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = mkdata(i, tags[i*6 +: 6]);
    #1;
    chk("req_ready", 128'(req_ready), 128'(exp_rdy));
    if (CHECK_EN && err_evt) err_model = 1'b1;
    e     = '0;
    e.v   = exp_bv;
    e.src = exp_src;
    e.err = err_model;
    for (int k = 0; k < 3; k++) begin
      if (exp_bv[k]) begin
        s = int'(exp_src[k*2 +: 2]);
        t = tags[s*6 +: 6];
        e.tag[k*6 +: 6]   = t;
        e.data[k*32 +: 32] = mkdata(s, t);
      end
    end
    q.push_back(e);
    @(negedge CLK);
  endtask

  task automatic chk_zero_outputs(input string phase);
    chk({phase, "_bus_valid"}, 128'(bus_valid), 128'(0));
    chk({phase, "_bus_tag"},   128'(bus_tag),   128'(0));
    chk({phase, "_bus_data"},  128'(bus_data),  128'(0));
    chk({phase, "_bus_src"},   128'(bus_src),   128'(0));
    chk({phase, "_DUT_error"}, 128'(DUT_error), 128'(0));
  endtask

  // Monitor: registered outputs appear one cycle after their grant.
  initial begin
    exp_t m;
    forever begin
      @(posedge CLK);
      #1;
      if (nRST && q.size() > 0) begin
        m = q.pop_front();
        chk("bus_valid", 128'(bus_valid), 128'(m.v));
        chk("bus_tag",   128'(bus_tag),   128'(m.tag));
        chk("bus_data",  128'(bus_data),  128'(m.data));
        chk("bus_src",   128'(bus_src),   128'(m.src));
        chk("DUT_error", 128'(DUT_error), 128'(m.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST      = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    #3;
    chk_zero_outputs("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    step(4'b0000, tg(0, 0, 0, 0), 4'b0000, 3'b000, 6'd0, 1'b0);
    step(4'b0000, tg(0, 0, 0, 0), 4'b0000, 3'b000, 6'd0, 1'b0);
    // Two sparse requesters from rr_ptr=0; pointer moves to 3.
    step(4'b0101, tg(0, 9, 0, 5), 4'b0101, 3'b011, {2'd0, 2'd2, 2'd0}, 1'b0);
    // Scan 3,0 wraps; pointer becomes 1.
    step(4'b1001, tg(11, 0, 0, 7), 4'b1001, 3'b011, {2'd0, 2'd0, 2'd3}, 1'b0);
    step(4'b0010, tg(0, 0, 4, 0), 4'b0010, 3'b001, {2'd0, 2'd0, 2'd1}, 1'b0);
    step(4'b0010, tg(0, 0, 4, 0), 4'b0010, 3'b001, {2'd0, 2'd0, 2'd1}, 1'b0);
    // Full load from rr_ptr=2.
    step(4'b1111, tg(4, 3, 2, 1), 4'b1101, 3'b111, {2'd0, 2'd3, 2'd2}, 1'b0);
    step(4'b1111, tg(4, 3, 2, 1), 4'b1110, 3'b111, {2'd3, 2'd2, 2'd1}, 1'b0);
    step(4'b1111, tg(4, 3, 2, 1), 4'b0111, 3'b111, {2'd2, 2'd1, 2'd0}, 1'b0);
    step(4'b0000, tg(0, 0, 0, 0), 4'b0000, 3'b000, 6'd0, 1'b0);
    // Duplicate tag 12 on requesters 1 and 2, rr_ptr=3.
    step(4'b0110, tg(0, 12, 12, 0), 4'b0110, 3'b011, {2'd0, 2'd2, 2'd1}, 1'b1);
    step(4'b0000, tg(0, 0, 0, 0), 4'b0000, 3'b000, 6'd0, 1'b0);
    // Granted tag 0.
    step(4'b0001, tg(0, 0, 0, 0), 4'b0001, 3'b001, {2'd0, 2'd0, 2'd0}, 1'b1);
    step(4'b1111, tg(4, 3, 2, 1), 4'b1110, 3'b111, {2'd3, 2'd2, 2'd1}, 1'b0);

    // Asynchronous reset while all buses are valid.
    chk("pre_reset_bus_valid", 128'(bus_valid), 128'(3'b111));
    #1;
    nRST      = 1'b0;
    err_model = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    @(negedge CLK);
    nRST = 1'b1;

    step(4'b1111, tg(4, 3, 2, 1), 4'b0111, 3'b111, {2'd2, 2'd1, 2'd0}, 1'b0);
    step(4'b1111, tg(4, 3, 2, 1), 4'b1011, 3'b111, {2'd1, 2'd0, 2'd3}, 1'b0);
    step(4'b0000, tg(0, 0, 0, 0), 4'b0000, 3'b000, 6'd0, 1'b0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
    chk("scoreboard_drain", 128'(q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
